// File: rtl/axi_master_pkg.sv
// Shared types and AXI encodings for the burst master.
package axi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Worst of two AXI responses (higher code is more severe).
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: accepts one command, runs AW/W/B or AR/R, reports a response.
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int          ADDR_WID = 32,
  parameter int          DATA_WID = 32,
  parameter int          ASIZE    = $clog2(DATA_WID/8),
  parameter int          STRBLEN  = DATA_WID/8,
  parameter logic [1:0]  RD_ID    = 2'b00
) (
  input  logic                aclk,
  input  logic                aresetn,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_WID-1:0] cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [ASIZE-1:0]    cmd_size,
  input  logic [1:0]          cmd_burst,
  // user write stream
  input  logic [DATA_WID-1:0] wr_data,
  input  logic [STRBLEN-1:0]  wr_strb,
  input  logic                wr_valid,
  output logic                wr_ready,
  // user read stream
  output logic [DATA_WID-1:0] rd_data,
  output logic                rd_last,
  output logic                rd_valid,
  input  logic                rd_ready,
  // completion
  output logic                done_valid,
  output logic [1:0]          done_resp,
  // AW
  output logic [ADDR_WID-1:0] awaddr,
  output logic [7:0]          awlen,
  output logic [ASIZE-1:0]    awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // W
  output logic [DATA_WID-1:0] wdata,
  output logic [STRBLEN-1:0]  wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // B
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  // AR
  output logic [1:0]          arid,
  output logic [ADDR_WID-1:0] araddr,
  output logic [7:0]          arlen,
  output logic [ASIZE-1:0]    arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  // R
  input  logic [DATA_WID-1:0] rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WID-1:0]   addr_q,  addr_d;
  logic [7:0]            len_q,   len_d;
  logic [ASIZE-1:0]      size_q,  size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q,   cnt_d;
  logic [1:0]            acc_q,   acc_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  last_beat;

  // Address payloads come straight from the command registers, so they hold under valid.
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = burst_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = burst_q;

  assign last_beat = (cnt_q == len_q);

  // State and command/status registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bresp_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bresp_q <= bresp_d;
    end
  end

  // Next-state, beat counting and per-state channel outputs.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    bresp_d    = bresp_q;

    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    rd_valid   = 1'b0;
    done_valid = 1'b0;
    done_resp  = '0;
    awvalid    = 1'b0;
    wdata      = '0;
    wstrb      = '0;
    wlast      = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    arid       = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          cnt_d   = '0;
          acc_d   = RESP_OKAY;
          state_d = cmd_write ? WADDR : RADDR;
        end
      end
      WADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = WDATA;
      end
      WDATA: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wdata    = wr_data;
        wstrb    = wr_strb;
        wlast    = last_beat;
        if (wr_valid && wready) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          bresp_d = bresp;
          state_d = DONE;
        end
      end
      RADDR: begin
        arvalid = 1'b1;
        arid    = RD_ID;
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        rd_valid = rvalid;
        rready   = rd_ready;
        rd_data  = rdata;
        rd_last  = rlast;
        if (rvalid && rd_ready) begin
          cnt_d = cnt_q + 8'd1;
          acc_d = resp_max(acc_q, rresp);
          // An rlast/length disagreement is an error; a missing rlast keeps draining.
          if (rlast) begin
            if (!last_beat) acc_d = RESP_SLVERR;
            state_d = DONE;
          end else if (last_beat) begin
            acc_d = RESP_SLVERR;
          end
        end
      end
      DONE: begin
        done_valid = 1'b1;
        done_resp  = write_q ? bresp_q : acc_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a behavioural AXI slave and user model.
module tb_axi_burst_master;
  import axi_master_pkg::*;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_size, cmd_burst;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awsize, awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [1:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arsize, arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  axi_burst_master #(
    .ADDR_WID(32), .DATA_WID(32), .ASIZE(2), .STRBLEN(4), .RD_ID(2'b00)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_resp(done_resp),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  logic out_any;
  assign out_any = |{wr_ready, rd_data, rd_last, rd_valid, done_valid, done_resp,
                     awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid,
                     bready, arid, araddr, arlen, arsize, arburst, arvalid, rready};

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] wbase;     // write beat i carries wbase+i
    logic [3:0]  strb;
    logic [31:0] rbase;     // read beat i must return rbase+i
    int          rlast_at;  // beat on which the slave raises rlast
    logic [1:0]  bresp;
    bit          stall;
    logic [1:0]  exp_resp;
    int          exp_beats;
  } vec_t;

  vec_t        vecs[13];
  vec_t        rst_vec;
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          failures = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int reload(input bit stall);
    return stall ? int'($urandom_range(0, 5)) : 0;
  endfunction

  task automatic clear_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
    awready = 0; wready = 0; bresp = '0; bvalid = 0; arready = 0;
    rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                              input logic [31:0] wbase, input logic [3:0] strb,
                              input logic [31:0] rbase, input int rlast_at,
                              input logic [1:0] br, input bit stall,
                              input logic [1:0] exp_resp, input int exp_beats);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.wbase = wbase; v.strb = strb;
    v.rbase = rbase; v.rlast_at = rlast_at; v.bresp = br; v.stall = stall;
    v.exp_resp = exp_resp; v.exp_beats = exp_beats;
    return v;
  endfunction

  // Runs one command end to end; rst_beat>=0 pulses reset once that many W beats are in.
  task automatic run_burst(input vec_t v, input int rst_beat);
    int          wbeat = 0, rbeat = 0, ar_idx = 0, aw_idx = 0;
    int          aw_wait, w_wait, uw_wait, ar_wait, r_wait, ur_wait;
    bit          aw_done = 0, b_pend = 0, r_pend = 0, seen_done = 0;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit          aw_hold = 0, ar_hold = 0, w_hold = 0;
    logic [63:0] aw_snap = '0, ar_snap = '0, w_snap = '0;
    aw_wait = reload(v.stall); w_wait = reload(v.stall); uw_wait = reload(v.stall);
    ar_wait = reload(v.stall); r_wait = reload(v.stall); ur_wait = reload(v.stall);

    @(negedge aclk);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    cmd_size = 2'd2; cmd_burst = BURST_INCR;
    #1 chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge aclk);
    cmd_valid = 0;

    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      if (rst_beat >= 0 && wbeat == rst_beat) begin
        aresetn = 0;
        clear_inputs();
        @(negedge aclk);
        aresetn = 1;
        #1;
        chk("rst_outputs_zero", 64'(out_any), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge aclk);
          #1 chk("rst_no_done", 64'(done_valid), 64'd0);
        end
        return;
      end
      awready  = (aw_wait == 0);
      wready   = (w_wait == 0);
      arready  = (ar_wait == 0);
      wr_valid = v.wr && (wbeat <= int'(v.len)) && (uw_wait == 0);
      wr_data  = v.wbase + 32'(wbeat);
      wr_strb  = v.strb;
      bvalid   = b_pend;
      bresp    = v.bresp;
      rvalid   = r_pend && (r_wait == 0);
      rdata    = mem[ar_idx + rbeat];
      rlast    = (rbeat == v.rlast_at);
      rresp    = RESP_OKAY;
      rd_ready = (ur_wait == 0);
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;

      if (aw_hold) chk("aw_stable", {19'd0, awvalid, awaddr, awlen, awsize, awburst}, aw_snap);
      if (ar_hold) chk("ar_stable", {17'd0, arvalid, arid, araddr, arlen, arsize, arburst}, ar_snap);
      if (w_hold)  chk("w_stable", {26'd0, wvalid, wdata, wstrb, wlast}, w_snap);
      if (wvalid && !aw_done) chk("w_before_aw", 64'(wvalid), 64'd0);

      if (aw_hs) begin
        chk("awaddr", 64'(awaddr), 64'(v.addr));
        chk("awlen", 64'(awlen), 64'(v.len));
        chk("awburst_size", {60'd0, awburst, awsize}, {60'd0, BURST_INCR, 2'd2});
        aw_done = 1;
        aw_idx  = int'(awaddr[11:2]);
      end
      if (ar_hs) begin
        chk("araddr", 64'(araddr), 64'(v.addr));
        chk("arlen_id", {54'd0, arlen, arid}, {54'd0, v.len, 2'b00});
        ar_idx = int'(araddr[11:2]);
        r_pend = 1;
      end
      if (w_hs) begin
        chk("wdata", 64'(wdata), 64'(v.wbase + 32'(wbeat)));
        chk("wlast", 64'(wlast), 64'(wbeat == int'(v.len)));
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem[aw_idx + wbeat][8*b +: 8] = wdata[8*b +: 8];
        if (wbeat == int'(v.len)) b_pend = 1;
        wbeat++;
      end
      if (b_hs) b_pend = 0;
      if (r_hs) begin
        chk("rd_data", 64'(rd_data), 64'(v.rbase + 32'(rbeat)));
        chk("rd_last", 64'(rd_last), 64'(rbeat == v.rlast_at));
        if (rlast) r_pend = 0;
        rbeat++;
      end
      if (done_valid) begin
        chk("done_resp", 64'(done_resp), 64'(v.exp_resp));
        seen_done = 1;
      end

      aw_hold = awvalid && !awready;
      ar_hold = arvalid && !arready;
      w_hold  = wvalid && !wready;
      aw_snap = {19'd0, awvalid, awaddr, awlen, awsize, awburst};
      ar_snap = {17'd0, arvalid, arid, araddr, arlen, arsize, arburst};
      w_snap  = {26'd0, wvalid, wdata, wstrb, wlast};
      aw_wait = aw_hs ? reload(v.stall) : (aw_wait > 0 ? aw_wait - 1 : 0);
      w_wait  = w_hs  ? reload(v.stall) : (w_wait  > 0 ? w_wait  - 1 : 0);
      uw_wait = w_hs  ? reload(v.stall) : (uw_wait > 0 ? uw_wait - 1 : 0);
      ar_wait = ar_hs ? reload(v.stall) : (ar_wait > 0 ? ar_wait - 1 : 0);
      r_wait  = r_hs  ? reload(v.stall) : (r_wait  > 0 ? r_wait  - 1 : 0);
      ur_wait = r_hs  ? reload(v.stall) : (ur_wait > 0 ? ur_wait - 1 : 0);
      @(negedge aclk);
    end

    if (!seen_done) chk("done_timeout", 64'd0, 64'd1);
    chk("beat_count", 64'(v.wr ? wbeat : rbeat), 64'(v.exp_beats));
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      #1 chk("done_single_pulse", 64'(done_valid), 64'd0);
      @(negedge aclk);
    end
    #1 chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    //            wr  addr      len    wbase         strb  rbase         rl   bresp stall resp  beats
    vecs[0]  = mk(1, 32'h010, 8'd3,   32'h0000_00A0, 4'hF, 32'h0,        0,   2'b00, 0, 2'b00, 4);
    vecs[1]  = mk(0, 32'h010, 8'd3,   32'h0,        4'h0, 32'h0000_00A0, 3,   2'b00, 0, 2'b00, 4);
    vecs[2]  = mk(1, 32'h040, 8'd0,   32'hDEAD_BEEF, 4'h3, 32'h0,        0,   2'b00, 0, 2'b00, 1);
    vecs[3]  = mk(0, 32'h040, 8'd0,   32'h0,        4'h0, 32'h0000_BEEF, 0,   2'b00, 0, 2'b00, 1);
    vecs[4]  = mk(1, 32'h080, 8'd7,   32'h1100_0000, 4'hF, 32'h0,        0,   2'b00, 1, 2'b00, 8);
    vecs[5]  = mk(0, 32'h080, 8'd7,   32'h0,        4'h0, 32'h1100_0000, 7,   2'b00, 1, 2'b00, 8);
    vecs[6]  = mk(0, 32'h010, 8'd4,   32'h0,        4'h0, 32'h0000_00A0, 2,   2'b00, 0, 2'b10, 3);
    vecs[7]  = mk(1, 32'h0C0, 8'd1,   32'h3333_0000, 4'hF, 32'h0,        0,   2'b11, 0, 2'b11, 2);
    vecs[8]  = mk(0, 32'h010, 8'd1,   32'h0,        4'h0, 32'h0000_00A0, 3,   2'b00, 0, 2'b10, 4);
    vecs[9]  = mk(1, 32'h400, 8'd255, 32'h5500_0000, 4'hF, 32'h0,        0,   2'b00, 0, 2'b00, 256);
    vecs[10] = mk(0, 32'h400, 8'd255, 32'h0,        4'h0, 32'h5500_0000, 255, 2'b00, 0, 2'b00, 256);
    vecs[11] = mk(1, 32'h240, 8'd1,   32'h7777_0000, 4'hF, 32'h0,        0,   2'b00, 0, 2'b00, 2);
    vecs[12] = mk(0, 32'h240, 8'd1,   32'h0,        4'h0, 32'h7777_0000, 1,   2'b00, 0, 2'b00, 2);
    rst_vec  = mk(1, 32'h200, 8'd3,   32'h9999_0000, 4'hF, 32'h0,        0,   2'b00, 0, 2'b00, 0);

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    clear_inputs();
    aresetn = 0;
    repeat (3) @(negedge aclk);
    #1;
    chk("reset_outputs_zero", 64'(out_any), 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge aclk);
    aresetn = 1;

    for (int i = 0; i < 13; i++) begin
      if (i == 11) run_burst(rst_vec, 2);
      run_burst(vecs[i], -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
